// File: rtl/fwd_hazard_unit_if.sv
// EX-stage hazard bus between the pipeline datapath (master) and fwd_hazard_unit (slave).
interface fwd_hazard_unit_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned SEL_W   = 2
);
    logic                        ex_valid_i;
    logic [NUM_SRC*REG_AW-1:0]   ex_src_i;
    logic [NUM_SRC-1:0]          ex_src_used_i;
    logic [REG_AW-1:0]           ex_rd_i;
    logic                        ex_reg_write_i;
    logic                        ex_is_load_i;
    logic                        flush_i;
    logic                        hold_i;
    logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o;
    logic                        stall_o;
    logic [31:0]                 stat_stall_o;
    logic [31:0]                 stat_fwd_o;

    modport master (
        output ex_valid_i, ex_src_i, ex_src_used_i, ex_rd_i, ex_reg_write_i,
               ex_is_load_i, flush_i, hold_i,
        input  fwd_sel_o, stall_o, stat_stall_o, stat_fwd_o
    );

    modport slave (
        input  ex_valid_i, ex_src_i, ex_src_used_i, ex_rd_i, ex_reg_write_i,
               ex_is_load_i, flush_i, hold_i,
        output fwd_sel_o, stall_o, stat_stall_o, stat_fwd_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand bypass select and load-use stall generation from a shift scoreboard of post-EX writers.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned REG_AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

    logic [FWD_DEPTH-1:0]       sb_valid;
    logic [FWD_DEPTH-1:0]       sb_load;
    logic [REG_AW-1:0]          sb_rd [FWD_DEPTH];

    logic [REG_AW-1:0]          src_c [NUM_SRC];
    logic [NUM_SRC-1:0]         qual_c;
    logic [NUM_SRC-1:0]         load_hit_c;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel_c;
    logic                       stall_c;
    logic                       cap_c;

    // Source decode and qualification
    always_comb begin
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            src_c[j]  = bus.ex_src_i[j*REG_AW +: REG_AW];
            qual_c[j] = bus.ex_valid_i & bus.ex_src_used_i[j] & (src_c[j] != '0);
        end
    end

    // Oldest-to-youngest scan so the youngest matching producer overwrites last
    always_comb begin
        fwd_sel_c  = '0;
        load_hit_c = '0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
                if (qual_c[j] && sb_valid[k] && (sb_rd[k] == src_c[j])) begin
                    fwd_sel_c[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
            load_hit_c[j] = qual_c[j] & sb_valid[0] & sb_load[0] & (sb_rd[0] == src_c[j]);
        end
        stall_c = (|load_hit_c) & ~bus.flush_i;
        cap_c   = bus.ex_valid_i & bus.ex_reg_write_i & (bus.ex_rd_i != '0) & ~bus.flush_i;
    end

    // Scoreboard shift; a stall inserts a bubble behind the stalled consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_rd[k] <= '0;
            end
        end else if (!bus.hold_i) begin
            sb_valid[0] <= cap_c & ~stall_c;
            sb_load[0]  <= cap_c & ~stall_c & bus.ex_is_load_i;
            sb_rd[0]    <= bus.ex_rd_i;
            for (int k = 1; k < int'(FWD_DEPTH); k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
        end
    end

    assign bus.fwd_sel_o = fwd_sel_c;
    assign bus.stall_o   = stall_c;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall_q;
    logic [31:0] stat_fwd_q;

    // Saturating event counters; frozen cycles are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= '0;
            stat_fwd_q   <= '0;
        end else if (!bus.hold_i) begin
            if (stall_c && (stat_stall_q != 32'hFFFF_FFFF)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            if ((|fwd_sel_c) && !stall_c && (stat_fwd_q != 32'hFFFF_FFFF)) begin
                stat_fwd_q <= stat_fwd_q + 32'd1;
            end
        end
    end

    assign bus.stat_stall_o = stat_stall_q;
    assign bus.stat_fwd_o   = stat_fwd_q;
`else
    assign bus.stat_stall_o = '0;
    assign bus.stat_fwd_o   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, corner sequences, random vs. history model.
module tb_fwd_hazard_unit;
    localparam int unsigned NUM_SRC   = 2;
    localparam int unsigned FWD_DEPTH = 2;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned SEL_W     = 2;
`ifdef FWD_HAZARD_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .SEL_W(SEL_W)) bus ();

    fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
        logic       hd;
        logic [1:0] e0;
        logic [1:0] e1;
        logic       est;
    } vec_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } prod_t;

    vec_t  tbl[$];
    prod_t hist[$];   // instructions that left EX, most recent first
    int    m_stall_cnt;
    int    m_fwd_cnt;

    function automatic vec_t mk(logic v, logic [4:0] s0, logic [4:0] s1, logic [1:0] used,
                                logic [4:0] rd, logic rw, logic ld, logic fl, logic hd,
                                logic [1:0] e0, logic [1:0] e1, logic est);
        vec_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.rd = rd; r.rw = rw;
        r.ld = ld; r.fl = fl; r.hd = hd; r.e0 = e0; r.e1 = e1; r.est = est;
        return r;
    endfunction

    task automatic apply(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic ld, input logic fl, input logic hd);
        bus.ex_valid_i     = v;
        bus.ex_src_i       = {s1, s0};
        bus.ex_src_used_i  = used;
        bus.ex_rd_i        = rd;
        bus.ex_reg_write_i = rw;
        bus.ex_is_load_i   = ld;
        bus.flush_i        = fl;
        bus.hold_i         = hd;
    endtask

    task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic fl, input logic hd);
        apply(v, s0, s1, used, rd, rw, ld, fl, hd);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " sel"},   32'(bus.fwd_sel_o), 32'd0);
        chk({tag, " stall"}, 32'(bus.stall_o),   32'd0);
        chk({tag, " sstat"}, bus.stat_stall_o,   32'd0);
        chk({tag, " fstat"}, bus.stat_fwd_o,     32'd0);
    endtask

    task automatic rand_inputs();
        apply(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 9) == 0));
    endtask

    function automatic logic [1:0] model_sel(logic [4:0] s, logic used);
        if (!bus.ex_valid_i || !used || s == 5'd0) return 2'd0;
        for (int i = 0; i < hist.size() && i < int'(FWD_DEPTH); i++) begin
            if (hist[i].v && hist[i].rd == s) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    function automatic logic model_load_hit(logic [4:0] s, logic used);
        if (!bus.ex_valid_i || !used || s == 5'd0 || hist.size() == 0) return 1'b0;
        return hist[0].v && hist[0].ld && hist[0].rd == s;
    endfunction

    initial begin
        logic [1:0] e0, e1;
        logic       est;
        prod_t      p;
        checks = 0; failures = 0;

        // Reset with random inputs applied
        rst_n = 1'b0;
        rand_inputs();
        #3 chk_reset("reset_a");
        #10 chk_reset("reset_b");
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #1 chk_reset("post_reset");
        @(negedge clk);

        //            v  s0  s1 used  rd rw ld fl hd  e0 e1 st
        tbl.push_back(mk(1,  1,  2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0)); // add x5
        tbl.push_back(mk(1,  5,  5, 2'b11, 6, 1, 0, 0, 0, 1, 1, 0)); // sub x6,x5,x5
        tbl.push_back(mk(1,  5,  6, 2'b11, 0, 0, 0, 0, 0, 2, 1, 0)); // gap for x5
        tbl.push_back(mk(1,  0,  0, 2'b00, 7, 1, 1, 0, 0, 0, 0, 0)); // lw x7
        tbl.push_back(mk(1,  7,  7, 2'b01, 8, 1, 0, 0, 0, 1, 0, 1)); // load-use stall
        tbl.push_back(mk(1,  7,  7, 2'b01, 8, 1, 0, 0, 0, 2, 0, 0)); // re-evaluated
        tbl.push_back(mk(1,  0,  0, 2'b00, 3, 1, 0, 0, 0, 0, 0, 0)); // write x3
        tbl.push_back(mk(1,  3,  0, 2'b01, 3, 1, 0, 0, 0, 1, 0, 0)); // write x3 again
        tbl.push_back(mk(1,  3,  3, 2'b11, 0, 1, 0, 0, 0, 1, 1, 0)); // youngest wins, rd=0
        tbl.push_back(mk(1,  0,  3, 2'b11, 4, 1, 0, 0, 0, 0, 2, 0)); // src x0
        tbl.push_back(mk(1,  4,  0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,  4,  4, 2'b11, 9, 1, 0, 0, 1, 2, 2, 0)); // hold x3
        tbl.push_back(mk(1,  4,  4, 2'b11, 9, 1, 0, 0, 1, 2, 2, 0));
        tbl.push_back(mk(1,  4,  4, 2'b11, 9, 1, 0, 0, 1, 2, 2, 0));
        tbl.push_back(mk(1,  4,  4, 2'b11, 0, 0, 0, 0, 0, 2, 2, 0));
        tbl.push_back(mk(1,  0,  0, 2'b00, 9, 1, 0, 1, 0, 0, 0, 0)); // flushed add x9
        tbl.push_back(mk(1,  9,  9, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  0,  0, 2'b00, 7, 1, 1, 0, 0, 0, 0, 0)); // lw x7
        tbl.push_back(mk(1,  7,  0, 2'b01, 0, 0, 0, 1, 0, 1, 0, 0)); // flush never stalls
        tbl.push_back(mk(1,  7,  0, 2'b01, 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1,  0,  0, 2'b00,10, 1, 1, 0, 0, 0, 0, 0)); // lw x10
        tbl.push_back(mk(1,  0, 10, 2'b10, 0, 0, 0, 0, 1, 0, 1, 1)); // stall under hold
        tbl.push_back(mk(1,  0, 10, 2'b10, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,  0, 10, 2'b10, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 10, 10, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0)); // EX not valid

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].rd,
                  tbl[i].rw, tbl[i].ld, tbl[i].fl, tbl[i].hd);
            #1;
            chk($sformatf("row%0d sel0", i),  32'(bus.fwd_sel_o[1:0]), 32'(tbl[i].e0));
            chk($sformatf("row%0d sel1", i),  32'(bus.fwd_sel_o[3:2]), 32'(tbl[i].e1));
            chk($sformatf("row%0d stall", i), 32'(bus.stall_o),        32'(tbl[i].est));
            @(negedge clk);
        end

        // Reset asserted in the middle of a load-use stall
        step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
        apply(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        #1 chk("midrst pre stall", 32'(bus.stall_o), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("midrst stall", 32'(bus.stall_o), 32'd0);
        chk("midrst sel", 32'(bus.fwd_sel_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Statistics: two load-use stalls and five forwarding cycles
        step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
        step(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
        step(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b00, 6, 1, 0, 0, 0);
        step(1, 0, 6, 2'b10, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #1;
        chk("stats stall", bus.stat_stall_o, STATS_ON ? 32'd2 : 32'd0);
        chk("stats fwd",   bus.stat_fwd_o,   STATS_ON ? 32'd5 : 32'd0);

        // Random traffic against the history model
        rst_n = 1'b0;
        #1 chk_reset("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            #1;
            e0  = model_sel(bus.ex_src_i[4:0], bus.ex_src_used_i[0]);
            e1  = model_sel(bus.ex_src_i[9:5], bus.ex_src_used_i[1]);
            est = !bus.flush_i && (model_load_hit(bus.ex_src_i[4:0], bus.ex_src_used_i[0]) ||
                                   model_load_hit(bus.ex_src_i[9:5], bus.ex_src_used_i[1]));
            chk($sformatf("rnd%0d sel0", c),  32'(bus.fwd_sel_o[1:0]), 32'(e0));
            chk($sformatf("rnd%0d sel1", c),  32'(bus.fwd_sel_o[3:2]), 32'(e1));
            chk($sformatf("rnd%0d stall", c), 32'(bus.stall_o),        32'(est));
            chk($sformatf("rnd%0d sstat", c), bus.stat_stall_o, STATS_ON ? 32'(m_stall_cnt) : 32'd0);
            chk($sformatf("rnd%0d fstat", c), bus.stat_fwd_o,   STATS_ON ? 32'(m_fwd_cnt)   : 32'd0);
            if (!bus.hold_i) begin
                p.v  = !est && bus.ex_valid_i && bus.ex_reg_write_i &&
                       bus.ex_rd_i != 5'd0 && !bus.flush_i;
                p.rd = bus.ex_rd_i;
                p.ld = bus.ex_is_load_i;
                hist.push_front(p);
                if (hist.size() > int'(FWD_DEPTH)) void'(hist.pop_back());
                if (est) m_stall_cnt++;
                else if (e0 != 2'd0 || e1 != 2'd0) m_fwd_cnt++;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the RISC-V pipeline. It tracks in-flight destination registers in its own shift scoreboard, so the datapath only presents the instruction leaving EX. It produces per-source bypass selects for the instruction in EX and a one-cycle load-use stall. It sits beside the EX stage and drives the operand bypass muxes plus the stall/bubble controls of IF/ID/EX.

## Interface
- NUM_SRC, 2, number of source operands checked per instruction (1..4)
- FWD_DEPTH, 2, tracked stages after EX (1..4); stage 0 = EX/MEM, stage 1 = MEM/WB, stage 2+ = post-WB bypass
- REG_AW, 5, register address width
- SEL_W, derived = $clog2(FWD_DEPTH+1), width of one select field
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid_i  in  1  EX holds a real instruction
- ex_src_i  in  NUM_SRC*REG_AW  source addresses of the EX instruction, src j at [j*REG_AW +: REG_AW]
- ex_src_used_i  in  NUM_SRC  source j is read
- ex_rd_i  in  REG_AW  EX destination
- ex_reg_write_i  in  1  EX writes rd
- ex_is_load_i  in  1  EX is a load (data ready only from stage 1)
- flush_i  in  1  kill the EX instruction (wrong path)
- hold_i  in  1  external freeze (memory wait)
- fwd_sel_o  out  NUM_SRC*SEL_W  per source: 0 = register file, k+1 = stage k
- stall_o  out  1  load-use stall: hold PC/IF/ID/EX, bubble into EX/MEM
- stat_stall_o  out  32  load-use stall cycle count (macro-gated)
- stat_fwd_o  out  32  forward event count (macro-gated)

## Operation
- Scoreboard: FWD_DEPTH entries {valid, rd, is_load}. An entry is valid only if reg_write=1 and rd!=0.
- Capture when `cap = ex_valid_i & ex_reg_write_i & ex_rd_i!=0 & ~flush_i`.
- Per clock, priority order:
  - hold_i=1: all entries unchanged.
  - else stall_o=1: entry0 <= invalid (bubble), entry k <= entry k-1.
  - else: entry0 <= cap ? {1, ex_rd_i, ex_is_load_i} : invalid, entry k <= entry k-1.
  - Entry FWD_DEPTH-1 drops off.
- Select for source j (combinational), qualified by ex_valid_i & ex_src_used_i[j] & ex_src_i[j]!=0:
  - choose the lowest k with entry k valid and rd==src; output k+1, else 0.
  - Youngest producer wins.
  - A stage-0 load match yields 1 but is overridden by stall.
- stall_o = OR over qualified sources of (entry0 valid & is_load & rd==src) & ~flush_i. flush_i never stalls.
- While stall_o=1, fwd_sel_o still reflects the current match. The consumer re-evaluates next cycle, when the load sits in stage 1 and the select becomes 2.
- hold_i does not mask stall_o or fwd_sel_o; the outputs remain a function of held state.

## Timing
- fwd_sel_o and stall_o are combinational from registered entries and the current EX inputs. No input-to-register latency beyond one edge.
- Producer in EX at cycle t is visible as stage 0 at t+1 and stage k at t+1+k (absent hold).
- A load-use stall lasts exactly 1 cycle unless hold_i extends it.
- Reset (async assert, sync-safe deassert): all entries invalid. fwd_sel_o=0, stall_o=0, stat counters=0.
- Reset mid-stall: stall_o drops immediately, since entries clear asynchronously.
- rd==0 is never tracked; src==0 always selects 0.

## Configuration
- FWD_HAZARD_STATS_EN defined:
  - stat_stall_o increments each cycle stall_o=1 & ~hold_i.
  - stat_fwd_o increments each cycle at least one fwd_sel field !=0 & ~stall_o & ~hold_i.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: no counter flops; both ports tie to 0.

## Test plan
- Reset: rst_n=0 with random inputs -> fwd_sel_o=0, stall_o=0, entries invalid.
- ALU back-to-back (default params):
  - EX: add x5, then EX: sub x6,x5,x5 -> fwd_sel_o={2'd1,2'd1}, stall_o=0.
  - One instruction gap -> {2'd2,2'd2}.
- Load-use: EX: lw x7, then EX src0=x7 -> stall_o=1 for 1 cycle with sel0=1. Next cycle sel0=2, stall_o=0.
- Priority and x0:
  - x3 written in stage 0 and stage 1 -> sel=1.
  - rd=0 producer -> sel=0.
  - src=x0 -> sel=0.
- Hold/flush:
  - hold_i=1 for 3 cycles -> selects stay constant.
  - flush_i=1 on add x9 -> next instruction reading x9 sees sel=0.
- Stats (macro on): 2 load-use stalls + 5 forward cycles -> stat_stall_o=2, stat_fwd_o=5. With the macro off, both read 0.
